// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and 8N1 frame line levels.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= LINE_IDLE;
      rx_s <= LINE_IDLE;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM, LSB-first shift register, and a valid/ready output byte register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE          = 8,
  parameter int unsigned CLKS_PER_BIT          = 8,
  parameter int unsigned NUM_OF_BITS_IN_BUFFER = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             rx,
  input  logic                             data_ready,
  output logic [NUM_OF_BITS_IN_BUFFER-1:0] data_out,
  output logic                             data_valid,
  output logic                             frame_error,
  output logic                             overrun,
  output logic                             busy
);

  localparam int unsigned BIT_W = (NUM_OF_BITS_IN_BUFFER > 1) ? $clog2(NUM_OF_BITS_IN_BUFFER) : 1;
  localparam logic [COUNTER_SIZE-1:0] HALF_M1  = COUNTER_SIZE'(CLKS_PER_BIT / 2 - 1);
  localparam logic [COUNTER_SIZE-1:0] FULL_M1  = COUNTER_SIZE'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]        LAST_IDX = BIT_W'(NUM_OF_BITS_IN_BUFFER - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be at least 4");
  end
  if ((2 ** COUNTER_SIZE) <= CLKS_PER_BIT) begin : g_bad_cnt
    $error("uart_rx: COUNTER_SIZE too small for CLKS_PER_BIT");
  end

  rx_state_t                        state, next_state;
  logic                             rx_s;
  logic [COUNTER_SIZE-1:0]          count;
  logic [BIT_W-1:0]                 bit_idx;
  logic [NUM_OF_BITS_IN_BUFFER-1:0] shift_reg;
  logic [NUM_OF_BITS_IN_BUFFER:0]   shift_next;
  logic                             data_sample;
  logic                             stop_sample;
  logic                             load;
  logic                             fe_set;
  logic                             ov_set;

  uart_rx_sync u_sync (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (rx_s == START_BIT) next_state = START;
      START: if (count == HALF_M1) next_state = (rx_s == START_BIT) ? DATA : IDLE;
      DATA:  if (count == FULL_M1 && bit_idx == LAST_IDX) next_state = STOP;
      STOP:  if (count == FULL_M1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    data_sample = (state == DATA) && (count == FULL_M1);
    stop_sample = (state == STOP) && (count == FULL_M1);
    load        = stop_sample && (rx_s == STOP_BIT) && (!data_valid || data_ready);
    fe_set      = stop_sample && (rx_s != STOP_BIT);
    ov_set      = stop_sample && (rx_s == STOP_BIT) && data_valid && !data_ready;
    busy        = (state != IDLE);
    // Newest bit enters at the MSB so the first (LSB) bit ends up at bit 0.
    shift_next  = {rx_s, shift_reg};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (state == IDLE || next_state != state || data_sample) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (data_sample) begin
      bit_idx   <= (bit_idx == LAST_IDX) ? '0 : bit_idx + 1'b1;
      shift_reg <= shift_next[NUM_OF_BITS_IN_BUFFER:1];
    end
  end

  // A load in the same cycle as a handshake keeps data_valid high with the new byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= fe_set;
      overrun     <= ov_set;
      if (load) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame bench for uart_rx with a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  logic       clock;
  logic       reset;
  logic       rx;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int fe_cycles = 0;
  int ov_cycles = 0;
  int dv_cycles = 0;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .COUNTER_SIZE          (8),
    .CLKS_PER_BIT          (CPB),
    .NUM_OF_BITS_IN_BUFFER (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data_ready  (data_ready),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observe between edges: what is seen here is what the next rising edge acts on.
  always @(negedge clock) begin
    if (frame_error === 1'b1) fe_cycles++;
    if (overrun === 1'b1) ov_cycles++;
    if (data_valid === 1'b1) dv_cycles++;
    if (reset === 1'b1 && data_valid === 1'b1 && data_ready === 1'b1) acc_q.push_back(data_out);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_count"}, acc_q.size(), exp_q.size());
    while (acc_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_byte"}, acc_q.pop_front(), exp_q.pop_front());
    acc_q.delete();
    exp_q.delete();
  endtask

  // Drives one full 8N1 frame; optionally pulses data_ready for exactly the stop-sample edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit ready_at_stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    if (ready_at_stop) begin
      tick(CPB - 2);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      tick(1);
    end else begin
      tick(CPB);
    end
    rx = 1'b1;
  endtask

  int         exp_fe = 0;
  int         exp_ov = 0;
  int         dv_base;
  logic [7:0] data_m;
  logic       valid_m;
  logic [7:0] rb;
  logic       rstop;
  logic       rready;

  initial begin
    reset      = 1'b0;
    rx         = 1'b1;
    data_ready = 1'b0;
    tick(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_fe", frame_error, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    tick(3);

    // Good frame with consumer ready: one-cycle valid, byte delivered.
    data_ready = 1'b1;
    dv_base = dv_cycles;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_valid", data_valid, 1'b0);
    check("a5_dv_cycles", dv_cycles - dv_base, 1);
    check("a5_fe", fe_cycles, exp_fe);
    check("a5_ov", ov_cycles, exp_ov);
    exp_q.push_back(8'hA5);
    check_acc("a5_acc");

    // Short low glitch aborts in START.
    data_ready = 1'b0;
    dv_base = dv_cycles;
    rx = 1'b0;
    tick(3);
    check("glitch_busy_hi", busy, 1'b1);
    rx = 1'b1;
    tick(6);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_dv", dv_cycles - dv_base, 0);
    check("glitch_fe", fe_cycles, exp_fe);
    check("glitch_ov", ov_cycles, exp_ov);

    // Bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2);
    exp_fe++;
    check("fe_pulse", fe_cycles, exp_fe);
    check("fe_valid", data_valid, 1'b0);
    check("fe_data_out", data_out, 8'hA5);
    check("fe_ov", ov_cycles, exp_ov);

    // Back-to-back frames, nobody consuming: second completes as overrun.
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2);
    exp_ov++;
    check("ovr_pulse", ov_cycles, exp_ov);
    check("ovr_data_out", data_out, 8'h11);
    check("ovr_valid", data_valid, 1'b1);
    check("ovr_fe", fe_cycles, exp_fe);

    // Ready arrives on the stop-sample edge: old byte taken, new one loads, no overrun.
    send_frame(8'h22, 1'b1, 1'b1);
    check("race_data_out", data_out, 8'h22);
    check("race_valid", data_valid, 1'b1);
    check("race_ov", ov_cycles, exp_ov);
    exp_q.push_back(8'h11);
    check_acc("race_acc");
    data_ready = 1'b1;
    tick(2);
    data_ready = 1'b0;
    check("race_drain_valid", data_valid, 1'b0);
    exp_q.push_back(8'h22);
    check_acc("race_drain_acc");

    // Reset in the middle of bit 4 of 0xFF, with a byte pending.
    send_frame(8'h77, 1'b1, 1'b0);
    tick(2);
    check("pre_rst_valid", data_valid, 1'b1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    check("mid_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 8'h00);
    check("mid_rst_valid", data_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fe", frame_error, 1'b0);
    check("mid_rst_ov", overrun, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(4);
    data_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(2);
    check("post_rst_data_out", data_out, 8'h5A);
    check("post_rst_fe", fe_cycles, exp_fe);
    check("post_rst_ov", ov_cycles, exp_ov);
    exp_q.push_back(8'h5A);
    check_acc("post_rst_acc");

    // Random frames against a frame-level model of the handshake.
    data_m  = 8'h5A;
    valid_m = 1'b0;
    for (int n = 0; n < 24; n++) begin
      rb     = 8'($urandom);
      rstop  = ($urandom_range(0, 3) != 0);
      rready = 1'($urandom_range(0, 1));
      data_ready = rready;
      tick(1);
      send_frame(rb, rstop, 1'b0);
      tick(3);
      if (valid_m && rready) begin
        exp_q.push_back(data_m);
        valid_m = 1'b0;
      end
      if (!rstop) begin
        exp_fe++;
      end else if (valid_m) begin
        exp_ov++;
      end else begin
        data_m  = rb;
        valid_m = 1'b1;
        if (rready) begin
          exp_q.push_back(rb);
          valid_m = 1'b0;
        end
      end
      check("rnd_valid", data_valid, valid_m);
      check("rnd_data_out", data_out, data_m);
      check("rnd_fe", fe_cycles, exp_fe);
      check("rnd_ov", ov_cycles, exp_ov);
      check_acc("rnd_acc");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
